// File: rtl/fetch_datapath.sv
// Instruction-fetch datapath: PC, MAR, MDR, IR around a muxed internal bus.
// Sequences PC->MAR, memory read (req/rdy with timeout), MDR->IR, PC step.
//
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Run, Continue     control FSM level run / single-step release pulse
//   pc_load(_val)     PC redirect, accepted in any state
//   mem_rdata/mem_rdy memory read data and completion
//   ADDR, mem_req     MAR contents and read request
//   pc_out, mdr_out, ir_out  register views
//   fetch_done        one-cycle pulse the cycle after IR loads
//   busy, err         non-idle flag, sticky read-timeout flag
//
// Config macro FETCH_PAUSE_EN: stop in PAUSE after each IR load until
// Continue. When undefined there is no PAUSE state and Continue is unused.

module fetch_datapath #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                PC_STEP  = 1,
    parameter int                TIMEOUT  = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Continue,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_load_val,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [ADDR_W-1:0] ADDR,
    output logic              mem_req,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic [DATA_W-1:0] ir_out,
    output logic              fetch_done,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last RD cycle index: the counter counts cycles already spent in RD.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_MAR = 3'd1,
        RD     = 3'd2,
`ifdef FETCH_PAUSE_EN
        LD_IR  = 3'd3,
        PAUSE  = 3'd4
`else
        LD_IR  = 3'd3
`endif
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] ir;
    logic [CNT_W-1:0]  cnt;
    logic              done_q;
    logic              err_q;

    logic ld_mar;
    logic ld_mdr;
    logic ld_ir;
    logic time_out;

`ifndef FETCH_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        ld_mar   = 1'b0;
        ld_mdr   = 1'b0;
        ld_ir    = 1'b0;
        time_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (Run && !err_q) state_nx = LD_MAR;
            end
            LD_MAR: begin
                ld_mar   = 1'b1;
                state_nx = RD;
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ld_mdr   = 1'b1;
                    state_nx = LD_IR;
                end else if (cnt == CNT_LAST) begin
                    time_out = 1'b1;
                    state_nx = IDLE;
                end
            end
            LD_IR: begin
                ld_ir = 1'b1;
`ifdef FETCH_PAUSE_EN
                state_nx = PAUSE;
`else
                state_nx = Run ? LD_MAR : IDLE;
`endif
            end
`ifdef FETCH_PAUSE_EN
            PAUSE: begin
                if (Continue) state_nx = Run ? LD_MAR : IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc     <= PC_RESET;
            mar    <= '0;
            mdr    <= '0;
            ir     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= ld_ir;
            // A redirect wins over the fetch increment; MAR still
            // captures the pre-redirect PC on the same edge.
            if (pc_load) begin
                pc <= pc_load_val;
            end else if (ld_mar) begin
                pc <= pc + DATA_W'(PC_STEP);
            end
            if (ld_mar) mar <= ADDR_W'(pc);
            if (ld_mdr) mdr <= mem_rdata;
            if (ld_ir)  ir  <= mdr;
            if (time_out) err_q <= 1'b1;
            if (mem_req && !mem_rdy && !time_out) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign ADDR       = mar;
    assign pc_out     = pc;
    assign mdr_out    = mdr;
    assign ir_out     = ir;
    assign fetch_done = done_q;
    assign busy       = (state != IDLE);
    assign err        = err_q;

endmodule
